// File: rtl/jtag_host_driver.sv
// jtag_host_driver
//
// Host-side JTAG initiator for the SoC debug module TAP. On-FPGA logic issues
// TAP reset, IR/DR scans and Run-Test/Idle cycles through a valid/ready command
// port. The captured TDO bits come back on a valid/ready response port. Every
// command starts and ends with the TAP in Run-Test/Idle.
//
// Parameters:
//   MaxLen - maximum scan length in bits, and the width of the data buses
//   ClkDiv - TCK half-period in clk_i cycles (>= 1)
//   LenW   - width of the length field (derived, do not override)
//
// Ports:
//   clk_i, rst_ni             - clock, synchronous active-low reset
//   req_valid_i / req_ready_o - command handshake
//   req_op_i                  - 00 TAP_RESET, 01 SCAN_IR, 10 SCAN_DR, 11 RUN_IDLE
//   req_len_i                 - scan length or idle TCK count (clamped to MaxLen)
//   req_data_i                - TDI data, LSB shifted first
//   rsp_valid_o / rsp_ready_i - response handshake
//   rsp_data_o                - captured TDO, bit i = i-th bit shifted out
//   busy_o                    - high from command accept until response handshake
//   jtag_tck_o/tms_o/tdi_o    - TAP pins, jtag_tdo_i TAP output
//   jtag_trst_no              - TAP reset, active low
//
// Build option:
//   JTAG_DRV_TDO_LATE_EN - when defined, TDO is sampled on the last clk_i cycle
//   before TCK falls instead of on the cycle TCK rises.

module jtag_host_driver #(
  parameter int unsigned MaxLen = 64,
  parameter int unsigned ClkDiv = 2,
  parameter int unsigned LenW   = $clog2(MaxLen + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [LenW-1:0]   req_len_i,
  input  logic [MaxLen-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  input  logic              jtag_tdo_i,
  output logic              jtag_trst_no
);

  localparam int unsigned DivW = $clog2(ClkDiv + 1);

  localparam logic [1:0] OpReset   = 2'b00;
  localparam logic [1:0] OpScanIr  = 2'b01;
  localparam logic [1:0] OpScanDr  = 2'b10;
  localparam logic [1:0] OpRunIdle = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StShift,
    StPost,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [MaxLen-1:0] data_q, data_d;
  logic [MaxLen-1:0] cap_q, cap_d;
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic [2:0]        pre_q, pre_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              trst_q;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic            running;
  logic            div_hit;
  logic            rise_ev;
  logic            fall_ev;
  logic            sample_ev;
  logic            scan_op;
  logic [LenW-1:0] len_clamped;
  logic [2:0]      pre_nxt;
  logic [2:0]      pre_last;

  // TMS value for step idx of the Idle -> Shift (or Idle -> TLR -> Idle) walk.
  function automatic logic pre_tms(input logic [1:0] op, input logic [2:0] idx);
    case (op)
      OpReset:  pre_tms = (idx < 3'd5);
      OpScanIr: pre_tms = (idx < 3'd2);
      default:  pre_tms = (idx == 3'd0);
    endcase
  endfunction

  assign running     = (state_q == StPre) || (state_q == StShift) || (state_q == StPost);
  assign div_hit     = (div_q == DivW'(ClkDiv - 1));
  assign rise_ev     = running && div_hit && !tck_q;
  assign fall_ev     = running && div_hit && tck_q;
  assign scan_op     = (op_q == OpScanIr) || (op_q == OpScanDr);
  assign len_clamped = (req_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : req_len_i;
  assign pre_nxt     = pre_q + 3'd1;

  always_comb begin
    case (op_q)
      OpReset:  pre_last = 3'd5;
      OpScanIr: pre_last = 3'd3;
      default:  pre_last = 3'd2;
    endcase
  end

`ifdef JTAG_DRV_TDO_LATE_EN
  // Last high-phase cycle; with ClkDiv == 1 that is the rising cycle itself.
  assign sample_ev = (ClkDiv == 1) ? rise_ev :
                     (running && tck_q && (int'(div_q) == int'(ClkDiv) - 2));
`else
  assign sample_ev = rise_ev;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    div_d       = div_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;

    // TCK divider: each half-period lasts ClkDiv cycles while a sequence runs.
    if (running) begin
      if (div_hit) begin
        div_d = '0;
        tck_d = ~tck_q;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end

    if (sample_ev && (state_q == StShift) && scan_op) begin
      for (int unsigned i = 0; i < MaxLen; i++) begin
        if (cnt_q == LenW'(i)) begin
          cap_d[i] = jtag_tdo_i;
        end
      end
    end

    // TMS/TDI for the next TCK period are loaded on the falling-edge cycle.
    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          op_d        = req_op_i;
          len_d       = len_clamped;
          data_d      = req_data_i;
          cap_d       = '0;
          cnt_d       = '0;
          pre_d       = '0;
          div_d       = '0;
          tck_d       = 1'b0;
          tdi_d       = 1'b0;
          if (req_op_i == OpReset) begin
            state_d = StPre;
            tms_d   = 1'b1;
          end else if (len_clamped == '0) begin
            // Empty scan or idle: answer immediately without touching TCK.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end else if (req_op_i == OpRunIdle) begin
            state_d = StShift;
            tms_d   = 1'b0;
          end else begin
            state_d = StPre;
            tms_d   = 1'b1;
          end
        end
      end

      StPre: begin
        if (fall_ev) begin
          if (pre_q == pre_last) begin
            if (op_q == OpReset) begin
              state_d = StResp;
            end else begin
              state_d = StShift;
              cnt_d   = '0;
              tms_d   = (len_q == LenW'(1));
              tdi_d   = data_q[0];
            end
          end else begin
            pre_d = pre_nxt;
            tms_d = pre_tms(op_q, pre_nxt);
          end
        end
      end

      StShift: begin
        if (fall_ev) begin
          if (cnt_q == len_q - LenW'(1)) begin
            tdi_d = 1'b0;
            if (op_q == OpRunIdle) begin
              state_d = StResp;
            end else begin
              state_d = StPost;
              pre_d   = '0;
              tms_d   = 1'b1;
            end
          end else begin
            cnt_d  = cnt_q + LenW'(1);
            data_d = data_q >> 1;
            tdi_d  = scan_op && data_q[1];
            // Last scan bit leaves Shift through Exit1.
            tms_d  = scan_op && (cnt_q + LenW'(2) == len_q);
          end
        end
      end

      StPost: begin
        if (fall_ev) begin
          if (pre_q == 3'd0) begin
            pre_d = 3'd1;
            tms_d = 1'b0;
          end else begin
            state_d = StResp;
          end
        end
      end

      StResp: begin
        // Entered on the final falling edge; valid rises one cycle later.
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= OpReset;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= 1'b1;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = cap_q;
  assign busy_o       = busy_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;

endmodule
